past_history_arbiter: RTL
=========================

Name: past_history_arbiter

Overview:
- Keeps a gated shift-register history of one sampled signal and serves "value k enabled samples ago" lookups. These are the hardware equivalent of $past(sig, k, gate).
- The history store is one shared resource. NREQ requesters share it through a round-robin arbiter that grants one read per cycle.
- Sits beside checker/monitor logic that needs past values in synthesizable form.

Parameters:
- DATA_W, 4, width of sampled signal din.
- DEPTH, 8, number of history entries; maximum lookback in samples (>=2).
- NREQ, 4, number of requesters (>=2).
- DLY_W, $clog2(DEPTH)+1, width of each delay field (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- sample_en  in  1  gating signal; history shifts only on edges where it is 1.
- din  in  DATA_W  value sampled into the history.
- flush  in  1  synchronous clear of the history fill count.
- req  in  NREQ  per-requester lookup request, level held until granted.
- req_dly  in  NREQ*DLY_W  per-requester lookback k; field i is bits [i*DLY_W +: DLY_W].
- gnt  out  NREQ  one-hot grant, registered, aligned with rsp_valid.
- rsp_valid  out  1  response present this cycle.
- rsp_id  out  $clog2(NREQ)  index of the served requester.
- rsp_data  out  DATA_W  past value.
- rsp_err  out  1  lookup invalid (k==0 or k>fill).
- fill  out  DLY_W  number of valid history entries, saturating at DEPTH.

Behaviour:
- Reset (rst_n=0, async): hist[*]=0, fill=0, rr pointer=0, gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
- History update, on posedge with sample_en=1:
  - hist[0]<=din; hist[j]<=hist[j-1].
  - fill<=min(fill+1, DEPTH).
  - With sample_en=0: history and fill hold.
- Flush: flush=1 sets fill<=0 and does not clear hist contents.
  - flush and sample_en together: fill<=1 and hist[0]<=din, i.e. flush applies first, then the sample.
- Lookup semantics: hist[k-1] at the edge equals $past(din,k,sample_en). Reads use pre-edge history, so a grant on an edge that also shifts returns the old value.
- Arbitration, each posedge:
  - Eligible set is req & ~gnt. A requester granted in the previous cycle is masked for one cycle, so a held req gets at most every other cycle.
  - Winner w is the first eligible index at or after ptr, wrapping modulo NREQ. Then ptr<=(w+1) mod NREQ.
  - If none eligible: gnt<=0, rsp_valid<=0; rsp_id/rsp_data/rsp_err hold.
- Latency: fixed 1 cycle from the sampling edge to gnt/rsp_valid.
  - The requester must drop req, or change req_dly, in the cycle it sees gnt.
  - req_dly must be stable while req is high and ungranted.
- Response on a win:
  - gnt<=onehot(w), rsp_valid<=1, rsp_id<=w.
  - If 1<=k<=fill (fill is the pre-edge value): rsp_data<=hist[k-1], rsp_err<=0.
  - Else: rsp_data<=0, rsp_err<=1. Covers k==0, k>fill after reset or flush, and k>DEPTH.
  - A flush on the same edge does not affect that edge's validity check.
- Reset mid-operation: an outstanding req is dropped. After release the requester is re-arbitrated from ptr=0 and its lookup gets rsp_err until enough samples have accumulated.

Decomposition:
- Package past_hist_pkg:
  - function calc_dly_w(depth).
  - function onehot_to_idx.
  - typedef struct rsp_t {id, data, err} parameterised via localparams of the including module.
- One sub-module, rr_arbiter (NREQ): inputs req_masked, ptr; outputs winner index and any_valid. It is purely combinational; the pointer register lives in the parent.
- The parent holds the history array, fill counter, pointer and output registers.

Test Plan:
- Fill and lookup: reset, then sample din=3,7,9,C with sample_en=1 (fill=4). Requester 0 asks k=1 -> rsp_data=C, rsp_err=0. k=4 -> 3. k=5 -> rsp_err=1, rsp_data=0.
- Gating: samples 1,2 with sample_en=1, then two edges with sample_en=0 and din=F. k=1 -> 2, fill=2.
- Round robin: all 4 req high with k=1, hist[0]=A. Grants are ordered 0,1,2,3 on consecutive cycles with rsp_id 0..3 and rsp_data=A each. ptr returns to 0.
- Masking: only req[2] held high for 6 cycles -> gnt[2] toggles 1,0,1,0,1,0; rsp_valid tracks it.
- Same-edge read/shift: hist[0]=5, din=6, sample_en=1, req k=1 on the same edge -> rsp_data=5. A later k=1 read -> 6.
- Flush and async reset: after 8 samples, assert flush -> fill=0 and k=1 gives rsp_err=1. Asserting rst_n=0 mid-burst clears gnt/rsp_valid immediately, without waiting for an edge.

Source files
------------

// File: rtl/past_history_arbiter_pkg.sv
// Shared helpers for the past-value history arbiter: width derivation and
// one-hot to index conversion.
package past_hist_pkg;

    function automatic int calc_dly_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Returns the index of the set bit; callers guarantee at most one bit is set.
    function automatic int onehot_to_idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/past_history_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set bit of i_req_masked at or after
// i_ptr, wrapping modulo NREQ. The pointer register lives in the parent.
module rr_arbiter
    import past_hist_pkg::*;
#(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req_masked,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any_valid
);

    logic [NREQ-1:0] w_onehot;

    always_comb begin
        logic           found;
        logic [IDX_W:0] idx_sum;
        w_onehot = '0;
        found    = 1'b0;
        idx_sum  = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (idx_sum >= (IDX_W+1)'(NREQ)) idx_sum = idx_sum - (IDX_W+1)'(NREQ);
            if (!found && i_req_masked[idx_sum[IDX_W-1:0]]) begin
                w_onehot[idx_sum[IDX_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign o_winner    = IDX_W'(onehot_to_idx(32'(w_onehot)));
    assign o_any_valid = |i_req_masked;

endmodule

// File: rtl/past_history_arbiter.sv
// Gated history of din with arbitrated "value k enabled samples ago" lookups,
// the synthesizable equivalent of $past(din, k, sample_en).
module past_history_arbiter
    import past_hist_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int DEPTH  = 8,
    parameter  int NREQ   = 4,
    localparam int DLY_W  = calc_dly_w(DEPTH),
    localparam int IDX_W  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic [DATA_W-1:0]     din,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DLY_W-1:0] req_dly,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    output logic [IDX_W-1:0]      rsp_id,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic [DLY_W-1:0]      fill
);

    localparam int HA_W = $clog2(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0]  id;
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    logic [DATA_W-1:0] r_hist [DEPTH];
    logic [DLY_W-1:0]  r_fill;
    logic [IDX_W-1:0]  r_ptr;
    logic [NREQ-1:0]   r_gnt;
    logic              r_rsp_valid;
    rsp_t              r_rsp;

    logic [NREQ-1:0]  w_req_masked;
    logic [IDX_W-1:0] w_winner;
    logic             w_any;
    logic [DLY_W-1:0] w_dly [NREQ];
    logic [DLY_W-1:0] w_k;
    logic [DLY_W-1:0] w_rd_idx;
    logic             w_k_ok;
    logic [IDX_W-1:0] w_next_ptr;

    // Handshake: req is level-held until gnt; gnt and rsp_* appear one cycle
    // after the winning edge, and the requester must drop req (or change
    // req_dly) in that cycle. The last winner is masked for one cycle.
    assign w_req_masked = req & ~r_gnt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req_masked (w_req_masked),
        .i_ptr        (r_ptr),
        .o_winner     (w_winner),
        .o_any_valid  (w_any)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) w_dly[i] = req_dly[i*DLY_W +: DLY_W];
    end

    // Validity uses the pre-edge fill, so a same-edge flush cannot affect it.
    assign w_k        = w_dly[w_winner];
    assign w_k_ok     = (w_k != '0) && (w_k <= r_fill);
    assign w_rd_idx   = w_k - 1'b1;
    assign w_next_ptr = (w_winner == IDX_W'(NREQ-1)) ? '0 : w_winner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) r_hist[j] <= '0;
            r_fill <= '0;
        end else begin
            if (sample_en) begin
                r_hist[0] <= din;
                for (int j = 1; j < DEPTH; j++) r_hist[j] <= r_hist[j-1];
                if (flush)                        r_fill <= DLY_W'(1);
                else if (r_fill != DLY_W'(DEPTH)) r_fill <= r_fill + 1'b1;
            end else if (flush) begin
                r_fill <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else if (w_any) begin
            r_ptr       <= w_next_ptr;
            r_gnt       <= NREQ'(1) << w_winner;
            r_rsp_valid <= 1'b1;
            r_rsp.id    <= w_winner;
            r_rsp.data  <= w_k_ok ? r_hist[w_rd_idx[HA_W-1:0]] : '0;
            r_rsp.err   <= ~w_k_ok;
        end else begin
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp.id;
    assign rsp_data  = r_rsp.data;
    assign rsp_err   = r_rsp.err;
    assign fill      = r_fill;

endmodule
